// File: rtl/tour_pkg.sv
// Shared types and constants for the knight-tour move sequencer.
package tour_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VERT,
        HOLDV,
        HORZ,
        HOLDH
    } state_t;

    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_FANFARE = 4'h3;

    localparam logic [7:0] HEAD_N = 8'h00;
    localparam logic [7:0] HEAD_W = 8'h3F;
    localparam logic [7:0] HEAD_S = 8'h7F;
    localparam logic [7:0] HEAD_E = 8'hBF;

    // Bit positions of the one-hot move vector, named by (dx,dy) direction
    localparam int MV_NNW = 0;
    localparam int MV_NNE = 1;
    localparam int MV_WNW = 2;
    localparam int MV_WSW = 3;
    localparam int MV_SSW = 4;
    localparam int MV_SSE = 5;
    localparam int MV_ESE = 6;
    localparam int MV_ENE = 7;

endpackage

// File: rtl/tour_move_sequencer_if.sv
// Command-path bundle between UART wrapper, solver memory and cmd_proc.
interface tour_move_sequencer_if;

    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic        tour_err;

    modport master (
        input  start_tour,
        input  move,
        input  cmd_UART,
        input  cmd_rdy_UART,
        input  clr_cmd_rdy,
        input  send_resp,
        output mv_indx,
        output clr_cmd_rdy_UART,
        output cmd,
        output cmd_rdy,
        output resp,
        output tour_err
    );

    modport slave (
        output start_tour,
        output move,
        output cmd_UART,
        output cmd_rdy_UART,
        output clr_cmd_rdy,
        output send_resp,
        input  mv_indx,
        input  clr_cmd_rdy_UART,
        input  cmd,
        input  cmd_rdy,
        input  resp,
        input  tour_err
    );

endinterface

// File: rtl/move_decode.sv
// Splits a one-hot knight move into sign/magnitude legs and flags
// anything that is not exactly one-hot.
module move_decode
    import tour_pkg::*;
(
    input  logic [7:0] move,
    output logic       dx_neg,
    output logic [1:0] dx_mag,
    output logic       dy_neg,
    output logic [1:0] dy_mag,
    output logic       valid
);

    always_comb begin
        dx_neg = 1'b0;
        dx_mag = 2'd0;
        dy_neg = 1'b0;
        dy_mag = 2'd0;
        case (1'b1)
            move[MV_NNW]: begin dx_neg = 1'b1; dx_mag = 2'd1; dy_mag = 2'd2; end
            move[MV_NNE]: begin dx_mag = 2'd1; dy_mag = 2'd2; end
            move[MV_WNW]: begin dx_neg = 1'b1; dx_mag = 2'd2; dy_mag = 2'd1; end
            move[MV_WSW]: begin
                dx_neg = 1'b1; dx_mag = 2'd2;
                dy_neg = 1'b1; dy_mag = 2'd1;
            end
            move[MV_SSW]: begin
                dx_neg = 1'b1; dx_mag = 2'd1;
                dy_neg = 1'b1; dy_mag = 2'd2;
            end
            move[MV_SSE]: begin dx_mag = 2'd1; dy_neg = 1'b1; dy_mag = 2'd2; end
            move[MV_ESE]: begin dx_mag = 2'd2; dy_neg = 1'b1; dy_mag = 2'd1; end
            move[MV_ENE]: begin dx_mag = 2'd2; dy_mag = 2'd1; end
            default: ;
        endcase
    end

    assign valid = $onehot(move);

endmodule

// File: rtl/tour_move_sequencer.sv
// Passes UART commands to cmd_proc, or during a tour replays each stored
// knight move as a vertical leg followed by a horizontal leg with fanfare.
module tour_move_sequencer
    import tour_pkg::*;
#(
    parameter int         NUM_MOVES = 24,
    parameter logic [7:0] RESP_ACK  = 8'hA5,
    parameter logic [7:0] RESP_DONE = 8'h5A
) (
    input logic                   clk,
    input logic                   rst,
    tour_move_sequencer_if.master bus
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

    state_t     state_q, state_d;
    logic [4:0] mv_indx_q, mv_indx_d;
    logic       tour_err_q, tour_err_d;

    logic        dx_neg, dy_neg, mv_ok;
    logic [1:0]  dx_mag, dy_mag;
    logic [15:0] vert_cmd, horz_cmd;
    logic        last_mv;

    move_decode u_dec (
        .move   (bus.move),
        .dx_neg (dx_neg),
        .dx_mag (dx_mag),
        .dy_neg (dy_neg),
        .dy_mag (dy_mag),
        .valid  (mv_ok)
    );

    assign vert_cmd = {OP_MOVE, dy_neg ? HEAD_S : HEAD_N, 2'b00, dy_mag};
    assign horz_cmd = {OP_FANFARE, dx_neg ? HEAD_W : HEAD_E, 2'b00, dx_mag};
    assign last_mv  = (mv_indx_q == LAST_IDX);

    always_comb begin
        state_d              = state_q;
        mv_indx_d            = mv_indx_q;
        tour_err_d           = tour_err_q;
        bus.cmd              = vert_cmd;
        bus.cmd_rdy          = 1'b0;
        bus.clr_cmd_rdy_UART = 1'b0;
        bus.resp             = RESP_ACK;
        case (state_q)
            IDLE: begin
                bus.cmd              = bus.cmd_UART;
                bus.cmd_rdy          = bus.cmd_rdy_UART;
                bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy;
                bus.resp             = RESP_DONE;
                if (bus.start_tour) begin
                    mv_indx_d = 5'd0;
                    state_d   = VERT;
                end
            end
            VERT: begin
                // A corrupt move aborts the tour before anything is issued
                if (!mv_ok) begin
                    tour_err_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    bus.cmd_rdy = 1'b1;
                    if (bus.clr_cmd_rdy) state_d = HOLDV;
                end
            end
            HOLDV: begin
                if (bus.send_resp) state_d = HORZ;
            end
            HORZ: begin
                bus.cmd     = horz_cmd;
                bus.cmd_rdy = 1'b1;
                if (bus.clr_cmd_rdy) state_d = HOLDH;
            end
            HOLDH: begin
                bus.cmd  = horz_cmd;
                bus.resp = last_mv ? RESP_DONE : RESP_ACK;
                if (bus.send_resp) begin
                    if (last_mv) begin
                        mv_indx_d = 5'd0;
                        state_d   = IDLE;
                    end else begin
                        mv_indx_d = mv_indx_q + 5'd1;
                        state_d   = VERT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            mv_indx_q  <= 5'd0;
            tour_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mv_indx_q  <= mv_indx_d;
            tour_err_q <= tour_err_d;
        end
    end

    assign bus.mv_indx  = mv_indx_q;
    assign bus.tour_err = tour_err_q;

endmodule

// File: tb/tb_tour_move_sequencer.sv
// Directed + randomized bench: acts as solver memory, UART wrapper and
// cmd_proc, checking each command against a (dx,dy) table model.
module tb_tour_move_sequencer;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   hs;

    logic [7:0] mem [32];
    int DX [8] = '{-1, 1, -2, -2, -1, 1, 2, 2};
    int DY [8] = '{ 2, 2,  1, -1, -2, -2, -1, 1};

    tour_move_sequencer_if bus ();

    assign bus.move = mem[bus.mv_indx];

    tour_move_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic int bitpos(input logic [7:0] m);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++) if (m[i]) p = i;
        return p;
    endfunction

    function automatic logic [15:0] exp_v(input logic [7:0] m);
        int dy;
        dy = DY[bitpos(m)];
        return {4'h2, (dy > 0) ? 8'h00 : 8'h7F, 4'((dy < 0) ? -dy : dy)};
    endfunction

    function automatic logic [15:0] exp_h(input logic [7:0] m);
        int dx;
        dx = DX[bitpos(m)];
        return {4'h3, (dx > 0) ? 8'hBF : 8'h3F, 4'((dx < 0) ? -dx : dx)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: got %h required %h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
        #1;
    endtask

    task automatic pulse_send();
        bus.send_resp = 1'b1;
        tick();
        bus.send_resp = 1'b0;
        #1;
    endtask

    task automatic wait_rdy(input string tag);
        int n;
        n = 0;
        while (bus.cmd_rdy !== 1'b1 && n < 20) begin
            tick();
            #1;
            n++;
        end
        chk(tag, {31'd0, bus.cmd_rdy}, 32'd1);
    endtask

    task automatic do_move(input int k);
        logic last;
        last = (k == 23);
        wait_rdy("v_rdy");
        chk("v_cmd", {16'd0, bus.cmd}, {16'd0, exp_v(mem[k])});
        chk("v_idx", {27'd0, bus.mv_indx}, k);
        chk("v_resp", {24'd0, bus.resp}, 32'hA5);
        pulse_send();
        chk("v_send_ign", {31'd0, bus.cmd_rdy}, 32'd1);
        repeat ($urandom_range(2, 0)) tick();
        bus.clr_cmd_rdy = 1'b1;
        #1;
        if (bus.cmd_rdy === 1'b1) hs++;
        chk("v_uclr", {31'd0, bus.clr_cmd_rdy_UART}, 32'd0);
        tick();
        bus.clr_cmd_rdy = 1'b0;
        #1;
        chk("hv_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        chk("hv_resp", {24'd0, bus.resp}, 32'hA5);
        pulse_clr();
        chk("hv_clr_ign", {31'd0, bus.cmd_rdy}, 32'd0);
        repeat ($urandom_range(2, 0)) tick();
        pulse_send();
        wait_rdy("h_rdy");
        chk("h_cmd", {16'd0, bus.cmd}, {16'd0, exp_h(mem[k])});
        chk("h_idx", {27'd0, bus.mv_indx}, k);
        bus.clr_cmd_rdy = 1'b1;
        #1;
        if (bus.cmd_rdy === 1'b1) hs++;
        tick();
        bus.clr_cmd_rdy = 1'b0;
        #1;
        chk("hh_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        chk("hh_resp", {24'd0, bus.resp}, last ? 32'h5A : 32'hA5);
        chk("hh_idx", {27'd0, bus.mv_indx}, k);
        pulse_send();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        hs    = 0;
        for (int i = 0; i < 32; i++) mem[i] = 8'(1 << $urandom_range(7, 0));
        rst              = 1'b1;
        bus.start_tour   = 1'b0;
        bus.cmd_UART     = 16'h0000;
        bus.cmd_rdy_UART = 1'b0;
        bus.clr_cmd_rdy  = 1'b0;
        bus.send_resp    = 1'b0;
        #2;
        chk("rst_idx", {27'd0, bus.mv_indx}, 32'd0);
        chk("rst_err", {31'd0, bus.tour_err}, 32'd0);
        chk("rst_resp", {24'd0, bus.resp}, 32'h5A);
        chk("rst_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        tick();
        rst = 1'b0;

        // pass-through
        bus.cmd_UART     = 16'h2002;
        bus.cmd_rdy_UART = 1'b1;
        #1;
        chk("pt_cmd", {16'd0, bus.cmd}, 32'h2002);
        chk("pt_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
        bus.clr_cmd_rdy = 1'b1;
        #1;
        chk("pt_clr", {31'd0, bus.clr_cmd_rdy_UART}, 32'd1);
        chk("pt_resp", {24'd0, bus.resp}, 32'hA5 ^ 32'hFF);
        tick();
        bus.clr_cmd_rdy  = 1'b0;
        bus.cmd_rdy_UART = 1'b0;
        #1;
        chk("pt_clr_lo", {31'd0, bus.clr_cmd_rdy_UART}, 32'd0);

        // bit1 then bit3, with a stray start_tour during HORZ
        mem[0] = 8'h02;
        mem[1] = 8'h08;
        bus.start_tour = 1'b1;
        tick();
        bus.start_tour = 1'b0;
        #1;
        chk("b1_v", {16'd0, bus.cmd}, 32'h2002);
        chk("b1_vrdy", {31'd0, bus.cmd_rdy}, 32'd1);
        pulse_clr();
        chk("b1_hold_resp", {24'd0, bus.resp}, 32'hA5);
        pulse_send();
        chk("b1_h", {16'd0, bus.cmd}, 32'h3BF1);
        bus.start_tour = 1'b1;
        tick();
        bus.start_tour = 1'b0;
        #1;
        chk("st_ign_cmd", {16'd0, bus.cmd}, 32'h3BF1);
        chk("st_ign_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
        chk("st_ign_idx", {27'd0, bus.mv_indx}, 32'd0);
        pulse_clr();
        chk("b1_hh_idx", {27'd0, bus.mv_indx}, 32'd0);
        pulse_send();
        chk("b3_idx", {27'd0, bus.mv_indx}, 32'd1);
        chk("b3_v", {16'd0, bus.cmd}, 32'h27F1);
        pulse_clr();
        pulse_send();
        chk("b3_h", {16'd0, bus.cmd}, 32'h33F2);
        chk("b3_h_idx", {27'd0, bus.mv_indx}, 32'd1);
        pulse_clr();
        chk("b3_hh_idx", {27'd0, bus.mv_indx}, 32'd1);
        pulse_send();
        chk("b3_next_idx", {27'd0, bus.mv_indx}, 32'd2);

        // reset while in HOLDV
        pulse_clr();
        bus.cmd_UART     = 16'h2BEE;
        bus.cmd_rdy_UART = 1'b1;
        #1;
        chk("hv_uart_ign", {31'd0, bus.cmd_rdy}, 32'd0);
        rst = 1'b1;
        #1;
        chk("ar_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
        chk("ar_cmd", {16'd0, bus.cmd}, 32'h2BEE);
        chk("ar_idx", {27'd0, bus.mv_indx}, 32'd0);
        chk("ar_resp", {24'd0, bus.resp}, 32'h5A);
        tick();
        rst              = 1'b0;
        bus.cmd_rdy_UART = 1'b0;

        // full randomized tour
        for (int i = 0; i < 24; i++) mem[i] = 8'(1 << $urandom_range(7, 0));
        hs = 0;
        bus.start_tour = 1'b1;
        tick();
        bus.start_tour = 1'b0;
        #1;
        for (int k = 0; k < 24; k++) begin
            if (k == 10) begin
                bus.cmd_UART     = 16'h2123;
                bus.cmd_rdy_UART = 1'b1;
            end
            do_move(k);
        end
        chk("tour_hs", hs, 32'd48);
        chk("tour_end_idx", {27'd0, bus.mv_indx}, 32'd0);
        chk("tour_end_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
        chk("tour_end_cmd", {16'd0, bus.cmd}, 32'h2123);
        chk("tour_end_resp", {24'd0, bus.resp}, 32'h5A);
        bus.clr_cmd_rdy = 1'b1;
        #1;
        chk("tour_end_clr", {31'd0, bus.clr_cmd_rdy_UART}, 32'd1);
        tick();
        bus.clr_cmd_rdy  = 1'b0;
        bus.cmd_rdy_UART = 1'b0;

        // illegal move at index 5
        for (int i = 0; i < 24; i++) mem[i] = 8'(1 << $urandom_range(7, 0));
        mem[5] = 8'h03;
        bus.start_tour = 1'b1;
        tick();
        bus.start_tour = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) do_move(k);
        chk("ill_idx", {27'd0, bus.mv_indx}, 32'd5);
        chk("ill_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        tick();
        #1;
        chk("ill_err", {31'd0, bus.tour_err}, 32'd1);
        chk("ill_idle_resp", {24'd0, bus.resp}, 32'h5A);
        chk("ill_idle_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        bus.cmd_rdy_UART = 1'b1;
        #1;
        chk("ill_idle_pt", {31'd0, bus.cmd_rdy}, 32'd1);
        repeat (3) tick();
        chk("err_sticky", {31'd0, bus.tour_err}, 32'd1);
        rst = 1'b1;
        #1;
        chk("err_clr", {31'd0, bus.tour_err}, 32'd0);
        tick();
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
